// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared widths, op codes and load helpers for the memory arbiter
package memory_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int INST_OP_WIDTH  = 4;

  localparam logic [XLEN-1:0] IO_ADDR = 32'h30000;

  localparam logic [INST_OP_WIDTH-1:0] LB  = 4'd0;
  localparam logic [INST_OP_WIDTH-1:0] LH  = 4'd1;
  localparam logic [INST_OP_WIDTH-1:0] LW  = 4'd2;
  localparam logic [INST_OP_WIDTH-1:0] LBU = 4'd3;
  localparam logic [INST_OP_WIDTH-1:0] LHU = 4'd4;
  localparam logic [INST_OP_WIDTH-1:0] SB  = 4'd5;
  localparam logic [INST_OP_WIDTH-1:0] SH  = 4'd6;
  localparam logic [INST_OP_WIDTH-1:0] SW  = 4'd7;

  function automatic logic [2:0] op_bytes(input logic [INST_OP_WIDTH-1:0] op);
    case (op)
      LB, LBU, SB: return 3'd1;
      LH, LHU, SH: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend_load(input logic [INST_OP_WIDTH-1:0] op,
                                                  input logic [XLEN-1:0] word);
    case (op)
      LB:      return {{24{word[7]}}, word[7:0]};
      LH:      return {{16{word[15]}}, word[15:0]};
      LBU:     return {24'b0, word[7:0]};
      LHU:     return {16'b0, word[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - serialises fetch, load and store accesses onto the byte-wide RAM/IO port
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      io_buffer_full,
  input  logic                      if_req,
  input  logic [XLEN-1:0]           if_addr,
  output logic                      if_ready,
  output logic [XLEN-1:0]           if_inst,
  input  logic                      lsb_mem_enable,
  input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
  input  logic [XLEN-1:0]           lsb_mem_addr,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,
  input  logic                      rob_store_enable,
  input  logic [INST_OP_WIDTH-1:0]  rob_store_op,
  input  logic [XLEN-1:0]           rob_store_addr,
  input  logic [XLEN-1:0]           rob_store_data,
  output logic                      mem_busy,
  output logic                      mem_data_ready,
  output logic [XLEN-1:0]           mem_data,
  output logic [ROB_SIZE_WIDTH-1:0] mem_id,
  output logic                      store_done,
  input  logic [7:0]                ram_din,
  output logic [7:0]                ram_dout,
  output logic [XLEN-1:0]           ram_a,
  output logic                      ram_wr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]                state;
  logic                      pend_valid, pend_store;
  logic [INST_OP_WIDTH-1:0]  pend_op, cur_op;
  logic [XLEN-1:0]           pend_addr, pend_data, cur_addr, cur_data;
  logic [ROB_SIZE_WIDTH-1:0] pend_id, cur_id;
  logic                      cur_fetch, wr_r;
  logic [2:0]                cnt, next_k, n_cur;
  logic [23:0]               rbuf;
  logic [XLEN-1:0]           asm_word;

  logic                      use_pend_st, use_pend_ld, st_avail, ld_avail;
  logic                      grant_store, grant_load, grant_fetch;
  logic [INST_OP_WIDTH-1:0]  st_op, ld_op;
  logic [XLEN-1:0]           st_addr, st_data, ld_addr;
  logic [ROB_SIZE_WIDTH-1:0] ld_id;

  // The slot takes precedence over a same-cycle pulse; requesters never pulse while it is full.
  assign use_pend_st = pend_valid && pend_store;
  assign use_pend_ld = pend_valid && !pend_store;
  assign st_avail    = use_pend_st || rob_store_enable;
  assign st_op       = use_pend_st ? pend_op   : rob_store_op;
  assign st_addr     = use_pend_st ? pend_addr : rob_store_addr;
  assign st_data     = use_pend_st ? pend_data : rob_store_data;
  assign ld_op       = use_pend_ld ? pend_op   : lsb_mem_op;
  assign ld_addr     = use_pend_ld ? pend_addr : lsb_mem_addr;
  assign ld_id       = use_pend_ld ? pend_id   : lsb_mem_id;
  assign ld_avail    = (use_pend_ld || lsb_mem_enable) && !flush;

  assign grant_store = (state == S_IDLE) && st_avail && !((st_addr == IO_ADDR) && io_buffer_full);
  assign grant_load  = (state == S_IDLE) && !st_avail && ld_avail;
  assign grant_fetch = (state == S_IDLE) && !st_avail && !ld_avail && if_req && !flush;

  assign mem_busy = pend_valid || lsb_mem_enable || rob_store_enable || (state != S_IDLE);
  assign ram_wr   = wr_r && rdy;
  assign n_cur    = op_bytes(cur_op);
  assign next_k   = cnt + 3'd1;

  // The last byte is taken straight from ram_din so the result is ready one cycle earlier.
  always_comb begin
    asm_word = '0;
    case (n_cur)
      3'd1:    asm_word = {24'b0, ram_din};
      3'd2:    asm_word = {16'b0, ram_din, rbuf[7:0]};
      default: asm_word = {ram_din, rbuf};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;  pend_valid <= 1'b0; pend_store <= 1'b0;
      pend_op <= '0;    pend_addr <= '0;    pend_data <= '0;  pend_id <= '0;
      cur_op <= '0;     cur_addr <= '0;     cur_data <= '0;   cur_id <= '0;
      cur_fetch <= 1'b0; cnt <= '0;         rbuf <= '0;       wr_r <= 1'b0;
      ram_a <= '0;      ram_dout <= '0;     if_ready <= 1'b0; if_inst <= '0;
      mem_data_ready <= 1'b0; mem_data <= '0; mem_id <= '0;   store_done <= 1'b0;
    end else if (rdy) begin
      if_ready       <= 1'b0;
      mem_data_ready <= 1'b0;
      store_done     <= 1'b0;

      if ((grant_store && use_pend_st) || (grant_load && use_pend_ld) || (flush && use_pend_ld))
        pend_valid <= 1'b0;
      if (lsb_mem_enable && !flush && !(grant_load && !use_pend_ld)) begin
        pend_valid <= 1'b1; pend_store <= 1'b0;
        pend_op <= lsb_mem_op; pend_addr <= lsb_mem_addr; pend_id <= lsb_mem_id;
      end
      if (rob_store_enable && !(grant_store && !use_pend_st)) begin
        pend_valid <= 1'b1; pend_store <= 1'b1;
        pend_op <= rob_store_op; pend_addr <= rob_store_addr; pend_data <= rob_store_data;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (grant_store) begin
            state <= S_WRITE; cur_op <= st_op; cur_addr <= st_addr; cur_data <= st_data;
            ram_a <= st_addr; ram_dout <= st_data[7:0]; wr_r <= 1'b1;
          end else if (grant_load) begin
            state <= S_READ; cur_op <= ld_op; cur_addr <= ld_addr; cur_id <= ld_id;
            cur_fetch <= 1'b0; ram_a <= ld_addr;
          end else if (grant_fetch) begin
            state <= S_READ; cur_op <= LW; cur_addr <= if_addr; cur_fetch <= 1'b1;
            ram_a <= if_addr;
          end
        end
        S_READ: begin
          if (flush) begin
            state <= S_IDLE;
            ram_a <= '0;
          end else begin
            case (cnt)
              3'd1:    rbuf[7:0]   <= ram_din;
              3'd2:    rbuf[15:8]  <= ram_din;
              3'd3:    rbuf[23:16] <= ram_din;
              default: ;
            endcase
            if (cnt == n_cur) begin
              state <= S_IDLE;
              if (cur_fetch) begin
                if_ready <= 1'b1;
                if_inst  <= asm_word;
              end else begin
                mem_data_ready <= 1'b1;
                mem_data       <= extend_load(cur_op, asm_word);
                mem_id         <= cur_id;
              end
            end else if (next_k < n_cur) begin
              ram_a <= cur_addr + {{(XLEN-3){1'b0}}, next_k};
            end else begin
              ram_a <= '0;
            end
            cnt <= next_k;
          end
        end
        S_WRITE: begin
          // Stores are already committed, so flush does not interrupt them.
          if (next_k == n_cur) begin
            state <= S_IDLE; wr_r <= 1'b0; ram_a <= '0; ram_dout <= '0;
            store_done <= 1'b1;
          end else begin
            ram_a    <= cur_addr + {{(XLEN-3){1'b0}}, next_k};
            ram_dout <= cur_data[{next_k[1:0], 3'b000} +: 8];
          end
          cnt <= next_k;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequences the CPU's single byte-wide RAM/IO port on behalf of three requesters: instruction fetch, the load/store buffer (loads issued speculatively), and the ROB (stores issued at commit). It serialises each word, halfword or byte access into per-byte RAM cycles. It returns assembled and extended load data with its ROB id, and drives the `mem_busy` back-pressure that gates load issue from the load/store buffer.

## Interface
- `XLEN`, 32, data/address width (from global params).
- `ROB_SIZE_WIDTH`, global, ROB id width.
- `IO_ADDR`, 32'h30000, address of the IO port.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; when low, all state holds.
- `flush`  in  1  mispredict flush.
- `io_buffer_full`  in  1  IO output buffer cannot accept a byte.
- `if_req`, `if_addr[XLEN]`  in  fetch request; level, held until `if_ready`.
- `if_ready`  out  1  one-cycle pulse; `if_inst` is valid.
- `if_inst`  out  XLEN  fetched word.
- `lsb_mem_enable`, `lsb_mem_op[INST_OP_WIDTH]`, `lsb_mem_addr[XLEN]`, `lsb_mem_id[ROB_SIZE_WIDTH]`  in  load issue; one-cycle pulse.
- `rob_store_enable`, `rob_store_op[INST_OP_WIDTH]`, `rob_store_addr[XLEN]`, `rob_store_data[XLEN]`  in  committed store; one-cycle pulse.
- `mem_busy`  out  1  combinational: `pend_valid | lsb_mem_enable | rob_store_enable | (state != IDLE)`.
- `mem_data_ready`  out  1  one-cycle pulse; load result valid.
- `mem_data`  out  XLEN  extended load result.
- `mem_id`  out  ROB_SIZE_WIDTH  ROB id of that load.
- `store_done`  out  1  one-cycle pulse; store fully written.
- `ram_din`  in  8  RAM read byte; reflects the address driven in the previous cycle.
- `ram_dout`  out  8  write byte.
- `ram_a`  out  XLEN  byte address.
- `ram_wr`  out  1  write strobe.

## Operation
- States: IDLE, READ, WRITE.
- Pending slot: one entry (`pend_valid`, `is_store`, op, addr, data, id). It captures any load/store pulse. Requesters never pulse while `mem_busy` is high, so a second pulse cannot arrive while the slot is full.
- Grant in IDLE, priority order:
  - The pending store, or a store pulse this cycle. If the address is `IO_ADDR` and `io_buffer_full` is high, the store waits in the slot.
  - The pending load, or a load pulse this cycle.
  - `if_req`, which is treated as LW semantics with no extension.
- Byte count N: B/BU → 1, H/HU → 2, W → 4.
- READ:
  - Drive `ram_a = addr + k` for k = 0..N-1 on consecutive cycles.
  - Capture `ram_din` one cycle later into byte lane k (little-endian).
- WRITE:
  - Drive `ram_a = addr + k`, `ram_dout = data[8k+7:8k]`, `ram_wr = 1` for k = 0..N-1.
- Extension:
  - LB and LH sign-extend from bit 7 and bit 15.
  - LBU and LHU zero-extend.
  - LW passes all 32 bits.
  - Address arithmetic is 32-bit and wraps mod 2^32.
- Completion:
  - Load → `mem_data_ready`, `mem_data`, `mem_id`.
  - Fetch → `if_ready`, `if_inst`.
  - Store → `store_done`.
  - The arbiter then returns to IDLE. No back-to-back overlap.
- Flush:
  - Aborts an in-flight READ (fetch or load): state → IDLE next cycle, no completion pulse.
  - Drops a pending load.
  - Stores, pending or in flight, are committed and always complete.
- Outside an active WRITE cycle, `ram_wr = 0`. In IDLE, `ram_a = 0`.

## Timing
- Reset: state IDLE, `pend_valid = 0`, and all outputs 0 (`ram_wr`, `ram_a`, `ram_dout`, `if_ready`, `if_inst`, `mem_data_ready`, `mem_data`, `mem_id`, `store_done`).
- Grant at cycle t, read of N bytes:
  - Byte k is addressed at cycle t+1+k and captured at cycle t+2+k.
  - The completion pulse is asserted at cycle t+N+2.
  - LW latency is 6 cycles and LB latency is 3 cycles.
- Grant at cycle t, write: bytes are driven at cycles t+1..t+N; `store_done` pulses at t+N+1.
- A load pulse at cycle t while a fetch is active → slot filled; the load is granted in the first IDLE cycle after the fetch completes.
- If a store pulse and a load pulse coincide in IDLE, the store is granted and the load goes to the slot. This does not occur in normal operation, but it is defined.
- Completion pulses last exactly one cycle; data outputs hold until the next completion.
- `rdy` low freezes every register, including the byte counter. `ram_wr` is forced to 0.

## Structure
- Shared `global_params.v` holds:
  - `XLEN`, `ROB_SIZE_WIDTH`, `INST_OP_WIDTH`.
  - The op codes `LB`, `LH`, `LW`, `LBU`, `LHU`, `SB`, `SH`, `SW`.
  - A new `IO_ADDR` define.
- State encodings are local parameters.
- No sub-module is needed. The byte-count and extension logic are local functions.

## Test plan
- Fetch of word 0xDEADBEEF at 0x1000, RAM little-endian → `ram_a` 0x1000..0x1003 on t+1..t+4; `if_ready` pulses at t+6 with `if_inst` = 0xDEADBEEF.
- LB id 5 at 0x20 holding byte 0x80 → `mem_data` = 0xFFFFFF80, `mem_id` = 5, pulse at t+3. LBU at the same address → 0x00000080.
- SH data 0x1234ABCD to 0x40 → `ram_wr` for two cycles: (0x40, 0xCD), (0x41, 0xAB); `store_done` pulses at t+3.
- Load pulse during an active fetch → `mem_busy` stays high; the load starts the cycle after `if_ready`; both results are correct.
- Flush in the middle of an LW → no `mem_data_ready`; state is IDLE next cycle. Flush during an SW → all 4 bytes are still written and `store_done` still pulses.
- SB to 0x30000 with `io_buffer_full = 1` for 5 cycles → no `ram_wr` while it is high; the write occurs 1 cycle after `io_buffer_full` falls.
